// File: rtl/loopback_pkg.sv
// Shared types and helpers for the HPIO loopback checker: FSM encoding,
// forwarded-clock lane patterns and a saturating increment.
package loopback_pkg;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      SLIP   = 2'd1,
      LOCKED = 2'd2
   } lb_state_e;

   localparam logic [7:0] CLK_PAT_A = 8'hAA;
   localparam logic [7:0] CLK_PAT_B = 8'h55;

   // Widths up to 64 bits; callers cast in and out of their own width.
   function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                           input logic [63:0] max_value);
      return (value >= max_value) ? value : value + 64'd1;
   endfunction

endpackage

// File: rtl/loopback_checker_if.sv
// RX lane byte stream from the RX FIFO read port, plus the forwarded-clock
// lane byte that travels with it.
interface loopback_checker_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] clk_lane_data;

   modport master (output rx_data, output rx_valid, output clk_lane_data);
   modport slave  (input  rx_data, input  rx_valid, input  clk_lane_data);
endinterface

// File: rtl/loopback_checker_byte_aligner.sv
// Stage 1 of the loopback checker: joins the previous and current RX byte and
// selects the 8-bit window starting bit_shift bits below the MSB.
module byte_aligner (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic [2:0] bit_shift,
   output logic [7:0] aligned_word,
   output logic       aligned_valid
);

   logic [7:0]  prev_byte_q, prev_byte_d;
   logic [7:0]  aligned_word_q, aligned_word_d;
   logic        aligned_valid_q, aligned_valid_d;
   logic [15:0] cat_shifted;

   always_comb begin
      // Left shift puts cat[15-bit_shift -: 8] in the top byte.
      cat_shifted     = {prev_byte_q, rx_data} << bit_shift;
      prev_byte_d     = prev_byte_q;
      aligned_word_d  = aligned_word_q;
      aligned_valid_d = rx_valid;
      if (rx_valid) begin
         aligned_word_d = cat_shifted[15:8];
         prev_byte_d    = rx_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_byte_q     <= 8'd0;
         aligned_word_q  <= 8'd0;
         aligned_valid_q <= 1'b0;
      end else begin
         prev_byte_q     <= prev_byte_d;
         aligned_word_q  <= aligned_word_d;
         aligned_valid_q <= aligned_valid_d;
      end
   end

   assign aligned_word  = aligned_word_q;
   assign aligned_valid = aligned_valid_q;

endmodule

// File: rtl/loopback_checker.sv
// Loopback checker: finds the RX bit rotation, locks to the TX counter pattern
// and counts words/errors. Define CLK_PATTERN_CHECK_EN to check the clock lane.
module loopback_checker
   import loopback_pkg::*;
#(
   parameter int LOCK_CNT   = 16,
   parameter int SLIP_WAIT  = 4,
   parameter int UNLOCK_CNT = 8,
   parameter int CNT_W      = 32
) (
   input  logic               clk,
   input  logic               rst,
   loopback_checker_if.slave  rx,
   input  logic               clr_counters,
   output logic [2:0]         bit_shift,
   output logic               locked,
   output logic               lock_lost,
   output logic [CNT_W-1:0]   word_count,
   output logic [CNT_W-1:0]   err_count,
   output logic [7:0]         aligned_word,
   output logic               aligned_valid,
   output logic               clk_pattern_err
);

   localparam logic [7:0]       LOCK_CNT_B   = 8'(LOCK_CNT);
   localparam logic [7:0]       SLIP_WAIT_B  = 8'(SLIP_WAIT);
   localparam logic [7:0]       UNLOCK_CNT_B = 8'(UNLOCK_CNT);
   localparam logic [CNT_W-1:0] CNT_MAX      = '1;

   logic [7:0] a_word;
   logic       a_valid;

   lb_state_e        state_q, state_d;
   logic [7:0]       ref_q, ref_d;
   logic             ref_valid_q, ref_valid_d;
   logic [7:0]       match_run_q, match_run_d;
   logic [7:0]       miss_run_q, miss_run_d;
   logic [7:0]       bad_run_q, bad_run_d;
   logic [7:0]       expected_q, expected_d;
   logic [2:0]       bit_shift_q, bit_shift_d;
   logic             locked_q, locked_d;
   logic             lock_lost_q, lock_lost_d;
   logic [CNT_W-1:0] word_count_q, word_count_d;
   logic [CNT_W-1:0] err_count_q, err_count_d;

   byte_aligner u_aligner (
      .clk           (clk),
      .rst           (rst),
      .rx_data       (rx.rx_data),
      .rx_valid      (rx.rx_valid),
      .bit_shift     (bit_shift_q),
      .aligned_word  (a_word),
      .aligned_valid (a_valid)
   );

   always_comb begin
      state_d      = state_q;
      ref_d        = ref_q;
      ref_valid_d  = ref_valid_q;
      match_run_d  = match_run_q;
      miss_run_d   = miss_run_q;
      bad_run_d    = bad_run_q;
      expected_d   = expected_q;
      bit_shift_d  = bit_shift_q;
      locked_d     = locked_q;
      lock_lost_d  = 1'b0;
      word_count_d = word_count_q;
      err_count_d  = err_count_q;

      if (a_valid) begin
         case (state_q)
            SEARCH: begin
               ref_d = a_word;
               if (!ref_valid_q) begin
                  ref_valid_d = 1'b1;
               end else if (a_word == ref_q + 8'd1) begin
                  match_run_d = match_run_q + 8'd1;
                  miss_run_d  = 8'd0;
                  if (match_run_d == LOCK_CNT_B) begin
                     state_d     = LOCKED;
                     locked_d    = 1'b1;
                     expected_d  = a_word + 8'd1;
                     match_run_d = 8'd0;
                     bad_run_d   = 8'd0;
                  end
               end else begin
                  match_run_d = 8'd0;
                  miss_run_d  = miss_run_q + 8'd1;
                  if (miss_run_d == SLIP_WAIT_B) begin
                     bit_shift_d = bit_shift_q + 3'd1;
                     state_d     = SLIP;
                  end
               end
            end
            // The word arriving now was cut with the old shift; drop it.
            SLIP: begin
               match_run_d = 8'd0;
               miss_run_d  = 8'd0;
               ref_valid_d = 1'b0;
               state_d     = SEARCH;
            end
            LOCKED: begin
               word_count_d = CNT_W'(sat_inc(64'(word_count_q), 64'(CNT_MAX)));
               expected_d   = expected_q + 8'd1;
               if (a_word != expected_q) begin
                  err_count_d = CNT_W'(sat_inc(64'(err_count_q), 64'(CNT_MAX)));
                  bad_run_d   = bad_run_q + 8'd1;
                  if (bad_run_d == UNLOCK_CNT_B) begin
                     state_d     = SEARCH;
                     locked_d    = 1'b0;
                     lock_lost_d = 1'b1;
                     ref_valid_d = 1'b0;
                     bad_run_d   = 8'd0;
                     match_run_d = 8'd0;
                     miss_run_d  = 8'd0;
                  end
               end else begin
                  bad_run_d = 8'd0;
               end
            end
            default: state_d = SEARCH;
         endcase
      end

      if (clr_counters) begin
         word_count_d = '0;
         err_count_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= SEARCH;
         ref_q        <= 8'd0;
         ref_valid_q  <= 1'b0;
         match_run_q  <= 8'd0;
         miss_run_q   <= 8'd0;
         bad_run_q    <= 8'd0;
         expected_q   <= 8'd0;
         bit_shift_q  <= 3'd0;
         locked_q     <= 1'b0;
         lock_lost_q  <= 1'b0;
         word_count_q <= '0;
         err_count_q  <= '0;
      end else begin
         state_q      <= state_d;
         ref_q        <= ref_d;
         ref_valid_q  <= ref_valid_d;
         match_run_q  <= match_run_d;
         miss_run_q   <= miss_run_d;
         bad_run_q    <= bad_run_d;
         expected_q   <= expected_d;
         bit_shift_q  <= bit_shift_d;
         locked_q     <= locked_d;
         lock_lost_q  <= lock_lost_d;
         word_count_q <= word_count_d;
         err_count_q  <= err_count_d;
      end
   end

`ifdef CLK_PATTERN_CHECK_EN
   logic [7:0] clk_ref_q, clk_ref_d;
   logic       clk_ref_valid_q, clk_ref_valid_d;
   logic       clk_err_q, clk_err_d;

   // The first clock-lane byte is taken as reference even when it is not a
   // legal pattern, so a bad first byte is flagged once rather than forever.
   always_comb begin
      clk_ref_d       = clk_ref_q;
      clk_ref_valid_d = clk_ref_valid_q;
      clk_err_d       = clk_err_q;
      if (rx.rx_valid) begin
         if (!clk_ref_valid_q) begin
            clk_ref_d       = rx.clk_lane_data;
            clk_ref_valid_d = 1'b1;
            if (rx.clk_lane_data != CLK_PAT_A && rx.clk_lane_data != CLK_PAT_B)
               clk_err_d = 1'b1;
         end else if (rx.clk_lane_data != clk_ref_q) begin
            clk_err_d = 1'b1;
         end
      end
      if (clr_counters)
         clk_err_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_ref_q       <= 8'd0;
         clk_ref_valid_q <= 1'b0;
         clk_err_q       <= 1'b0;
      end else begin
         clk_ref_q       <= clk_ref_d;
         clk_ref_valid_q <= clk_ref_valid_d;
         clk_err_q       <= clk_err_d;
      end
   end

   assign clk_pattern_err = clk_err_q;
`else
   logic unused_clk_lane;
   assign unused_clk_lane = ^rx.clk_lane_data;
   assign clk_pattern_err = 1'b0;
`endif

   assign bit_shift     = bit_shift_q;
   assign locked        = locked_q;
   assign lock_lost     = lock_lost_q;
   assign word_count    = word_count_q;
   assign err_count     = err_count_q;
   assign aligned_word  = a_word;
   assign aligned_valid = a_valid;

endmodule

// File: tb/tb_loopback_checker.sv
// Bench for loopback_checker: counter-pattern streams with rotation, error
// injection, clear/stall and the optional clock-lane pattern check.
module tb_loopback_checker;

   logic        clk = 1'b0;
   logic        rst;
   logic        clr_counters;
   logic [2:0]  bit_shift;
   logic        locked;
   logic        lock_lost;
   logic [31:0] word_count;
   logic [31:0] err_count;
   logic [7:0]  aligned_word;
   logic        aligned_valid;
   logic        clk_pattern_err;

   always #5 clk = ~clk;

   loopback_checker_if lb_if ();

   loopback_checker dut (
      .clk             (clk),
      .rst             (rst),
      .rx              (lb_if),
      .clr_counters    (clr_counters),
      .bit_shift       (bit_shift),
      .locked          (locked),
      .lock_lost       (lock_lost),
      .word_count      (word_count),
      .err_count       (err_count),
      .aligned_word    (aligned_word),
      .aligned_valid   (aligned_valid),
      .clk_pattern_err (clk_pattern_err)
   );

`ifdef CLK_PATTERN_CHECK_EN
   localparam logic CPE_EN = 1'b1;
`else
   localparam logic CPE_EN = 1'b0;
`endif

   int         n_cmp = 0;
   int         n_err = 0;
   int         lost_pulses = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mon_exp;
   logic [7:0] tx_cnt;
   logic [7:0] last_rx;
   logic [7:0] clk_byte;
   int         rot;

   // Scoreboard: each checked send pushes the aligned byte it must produce.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_exp = exp_q.pop_front();
         n_cmp++;
         if (aligned_valid !== 1'b1 || aligned_word !== mon_exp) begin
            n_err++;
            $display("FAIL aligned_word: got %h (valid %b) expected %h", aligned_word, aligned_valid, mon_exp);
         end
      end
   end

   initial begin
      #200us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] stream_byte(input logic [7:0] c, input int r);
      logic [15:0] w;
      w = {c, c + 8'd1} << r;
      return w[15:8];
   endfunction

   task automatic send(input logic [7:0] b, input logic [7:0] exp, input logic chk, input logic clr);
      @(negedge clk);
      lb_if.rx_data       = b;
      lb_if.rx_valid      = 1'b1;
      lb_if.clk_lane_data = clk_byte;
      clr_counters        = clr;
      if (chk) exp_q.push_back(exp);
      last_rx = b;
      @(posedge clk);
      #1;
      lb_if.rx_valid = 1'b0;
      clr_counters   = 1'b0;
      lost_pulses += int'(lock_lost);
   endtask

   task automatic send_stream(input logic bad, input logic clr, input logic chk);
      logic [7:0] b;
      logic [7:0] e;
      b = bad ? 8'hFF : stream_byte(tx_cnt, rot);
      e = (rot == 0) ? last_rx : tx_cnt;
      send(b, e, chk, clr);
      tx_cnt = tx_cnt + 8'd1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         lost_pulses += int'(lock_lost);
      end
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      clr_counters = 1'b1;
      @(posedge clk);
      #1;
      clr_counters = 1'b0;
   endtask

   task automatic do_reset();
      rst                 = 1'b1;
      clr_counters        = 1'b0;
      lb_if.rx_valid      = 1'b0;
      lb_if.rx_data       = 8'h00;
      clk_byte            = 8'hAA;
      lb_if.clk_lane_data = 8'hAA;
      exp_q.delete();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst     = 1'b0;
      last_rx = 8'h00;
      tx_cnt  = 8'h00;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL reset_locked: got %b expected 0", locked); end
      n_cmp++; if (lock_lost !== 1'b0) begin n_err++; $display("FAIL reset_lock_lost: got %b expected 0", lock_lost); end
      n_cmp++; if (bit_shift !== 3'd0) begin n_err++; $display("FAIL reset_bit_shift: got %0d expected 0", bit_shift); end
      n_cmp++; if (word_count !== 32'd0) begin n_err++; $display("FAIL reset_word_count: got %0d expected 0", word_count); end
      n_cmp++; if (err_count !== 32'd0) begin n_err++; $display("FAIL reset_err_count: got %0d expected 0", err_count); end
      n_cmp++; if (aligned_valid !== 1'b0 || aligned_word !== 8'h00) begin n_err++; $display("FAIL reset_aligned: got %h/%b expected 00/0", aligned_word, aligned_valid); end
      n_cmp++; if (clk_pattern_err !== 1'b0) begin n_err++; $display("FAIL reset_clk_pattern_err: got %b expected 0", clk_pattern_err); end
   endtask

   task automatic test_lock_aligned();
      rot = 0;
      for (int i = 0; i <= 40; i++) begin
         send_stream(1'b0, 1'b0, 1'b1);
         if (i == 17) begin
            n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL lock_early: got %b expected 0 after byte 17", locked); end
         end
         if (i == 18) begin
            n_cmp++; if (locked !== 1'b1) begin n_err++; $display("FAIL lock_rise: got %b expected 1 after byte 18", locked); end
         end
      end
      n_cmp++; if (bit_shift !== 3'd0) begin n_err++; $display("FAIL lock0_bit_shift: got %0d expected 0", bit_shift); end
      n_cmp++; if (err_count !== 32'd0) begin n_err++; $display("FAIL lock0_err_count: got %0d expected 0", err_count); end
      n_cmp++; if (word_count !== 32'd22) begin n_err++; $display("FAIL lock0_word_count: got %0d expected 22", word_count); end
   endtask

   task automatic test_single_error();
      send_stream(1'b1, 1'b0, 1'b1);
      repeat (4) send_stream(1'b0, 1'b0, 1'b1);
      n_cmp++; if (err_count !== 32'd1) begin n_err++; $display("FAIL single_err_count: got %0d expected 1", err_count); end
      n_cmp++; if (locked !== 1'b1) begin n_err++; $display("FAIL single_locked: got %b expected 1", locked); end
   endtask

   task automatic test_unlock_relock();
      int guard;
      pulse_clr();
      n_cmp++; if (err_count !== 32'd0 || word_count !== 32'd0) begin n_err++; $display("FAIL clr_idle: got wc %0d err %0d expected 0/0", word_count, err_count); end
      lost_pulses = 0;
      repeat (8) send_stream(1'b1, 1'b0, 1'b1);
      send_stream(1'b0, 1'b0, 1'b1);
      n_cmp++; if (locked !== 1'b1 || err_count !== 32'd7) begin n_err++; $display("FAIL burst_7: got locked %b err %0d expected 1/7", locked, err_count); end
      send_stream(1'b0, 1'b0, 1'b1);
      n_cmp++; if (locked !== 1'b0 || lock_lost !== 1'b1 || err_count !== 32'd8) begin n_err++; $display("FAIL burst_8: got locked %b lost %b err %0d expected 0/1/8", locked, lock_lost, err_count); end
      send_stream(1'b0, 1'b0, 1'b1);
      n_cmp++; if (lock_lost !== 1'b0) begin n_err++; $display("FAIL lock_lost_pulse: got %b expected 0", lock_lost); end
      guard = 0;
      while (locked !== 1'b1 && guard < 40) begin
         send_stream(1'b0, 1'b0, 1'b1);
         guard++;
      end
      n_cmp++; if (locked !== 1'b1 || bit_shift !== 3'd0) begin n_err++; $display("FAIL relock: got locked %b shift %0d expected 1/0", locked, bit_shift); end
      n_cmp++; if (lost_pulses !== 1) begin n_err++; $display("FAIL lost_pulse_count: got %0d expected 1", lost_pulses); end
   endtask

   task automatic test_clear_stall();
      send_stream(1'b1, 1'b0, 1'b1);
      send_stream(1'b0, 1'b0, 1'b1);
      send_stream(1'b0, 1'b1, 1'b1);
      n_cmp++; if (word_count !== 32'd0 || err_count !== 32'd0) begin n_err++; $display("FAIL clr_vs_err: got wc %0d err %0d expected 0/0", word_count, err_count); end
      idle(1);
      n_cmp++; if (word_count !== 32'd1) begin n_err++; $display("FAIL drain_word: got %0d expected 1", word_count); end
      idle(9);
      n_cmp++; if (word_count !== 32'd1 || err_count !== 32'd0) begin n_err++; $display("FAIL stall_counts: got wc %0d err %0d expected 1/0", word_count, err_count); end
      n_cmp++; if (locked !== 1'b1 || aligned_valid !== 1'b0 || bit_shift !== 3'd0) begin n_err++; $display("FAIL stall_state: got locked %b av %b shift %0d expected 1/0/0", locked, aligned_valid, bit_shift); end
      repeat (5) send_stream(1'b0, 1'b0, 1'b1);
      n_cmp++; if (word_count !== 32'd5 || err_count !== 32'd0) begin n_err++; $display("FAIL resume: got wc %0d err %0d expected 5/0", word_count, err_count); end
   endtask

   task automatic test_rotated();
      int guard;
      do_reset();
      n_cmp++; if (locked !== 1'b0 || word_count !== 32'd0) begin n_err++; $display("FAIL reset_midlock: got locked %b wc %0d expected 0/0", locked, word_count); end
      rot = 3;
      guard = 0;
      while (locked !== 1'b1 && guard < 600) begin
         send_stream(1'b0, 1'b0, 1'b0);
         guard++;
      end
      n_cmp++; if (locked !== 1'b1) begin n_err++; $display("FAIL rot_lock: got %b expected 1 within 600 bytes", locked); end
      n_cmp++; if (bit_shift !== 3'd5) begin n_err++; $display("FAIL rot_bit_shift: got %0d expected 5", bit_shift); end
      repeat (20) send_stream(1'b0, 1'b0, 1'b1);
      n_cmp++; if (err_count !== 32'd0 || locked !== 1'b1) begin n_err++; $display("FAIL rot_clean: got err %0d locked %b expected 0/1", err_count, locked); end
   endtask

   task automatic test_clk_pattern();
      repeat (3) send_stream(1'b0, 1'b0, 1'b1);
      n_cmp++; if (clk_pattern_err !== 1'b0) begin n_err++; $display("FAIL clkpat_clean: got %b expected 0", clk_pattern_err); end
      clk_byte = 8'h55;
      send_stream(1'b0, 1'b0, 1'b1);
      n_cmp++; if (clk_pattern_err !== CPE_EN) begin n_err++; $display("FAIL clkpat_set: got %b expected %b", clk_pattern_err, CPE_EN); end
      clk_byte = 8'hAA;
      send_stream(1'b0, 1'b0, 1'b1);
      n_cmp++; if (clk_pattern_err !== CPE_EN) begin n_err++; $display("FAIL clkpat_sticky: got %b expected %b", clk_pattern_err, CPE_EN); end
      pulse_clr();
      n_cmp++; if (clk_pattern_err !== 1'b0) begin n_err++; $display("FAIL clkpat_clear: got %b expected 0", clk_pattern_err); end
   endtask

   initial begin
      test_reset();
      test_lock_aligned();
      test_single_error();
      test_unlock_relock();
      test_clear_stall();
      test_rotated();
      test_clk_pattern();
      idle(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/loopback_checker.md
Name: loopback_checker

Overview:
- Consumes deserialised 8-bit RX lane bytes from the HPIO receive path in the loopback test, downstream of the RX FIFO read port. Runs in the fabric clock domain.
- Finds the bit rotation between the TX byte boundary and the RX byte boundary.
- Locks onto the incrementing-counter test pattern driven by the TX side.
- Counts words and mismatches, and reports lock status to the ILA and status LEDs.

Parameters:
- LOCK_CNT, 16: consecutive +1 steps required in SEARCH before entering LOCKED (range 2..255).
- SLIP_WAIT, 4: consecutive non-+1 steps in SEARCH before advancing the bit shift (range 1..255).
- UNLOCK_CNT, 8: consecutive mismatches in LOCKED before dropping lock (range 1..255).
- CNT_W, 32: width of word_count and err_count.

Ports:
- clk  in  1  fabric clock (100 MHz in the loopback build); everything is rising-edge.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  RX lane byte from the RX FIFO, MSB first on the wire.
- rx_valid  in  1  qualifies rx_data; driven from the FIFO read-data-valid.
- clr_counters  in  1  single-cycle synchronous clear of word_count and err_count.
- clk_lane_data  in  8  byte from the forwarded-clock lane. Used only with CLK_PATTERN_CHECK_EN.
- bit_shift  out  3  current alignment offset.
- locked  out  1  high while the FSM is in LOCKED.
- lock_lost  out  1  one-cycle pulse on the LOCKED->SEARCH transition.
- word_count  out  CNT_W  words checked while LOCKED; saturates.
- err_count  out  CNT_W  mismatches while LOCKED; saturates.
- aligned_word  out  8  registered, re-aligned byte, for ILA probing.
- aligned_valid  out  1  qualifies aligned_word.
- clk_pattern_err  out  1  sticky flag. Held at 0 when the feature is compiled out.

Behaviour:
- Reset (rst=1 at a clk edge): all outputs 0, FSM=SEARCH, bit_shift=0, internal prev_byte=0, all run counters 0, ref_valid=0. A reset mid-lock drops lock on the next edge.
- Stage 1 (alignment), on rx_valid:
  - cat = {prev_byte, rx_data} (16 bits); aligned_word <= cat[15-bit_shift -: 8]; aligned_valid <= 1; prev_byte <= rx_data.
  - With rx_valid=0: aligned_valid <= 0 and all state holds.
  - With shift 0, aligned_word = prev_byte, so latency is one valid byte plus one clock.
- Stage 2 (check) acts on aligned_valid. Counters and FSM update one clock after aligned_valid.
- SEARCH:
  - ref_valid=0: ref <= aligned_word; ref_valid <= 1.
  - word == ref+1 (mod 256): match_run++, miss_run <= 0.
  - Otherwise: match_run <= 0, miss_run++.
  - ref <= word on every valid word.
  - match_run reaching LOCK_CNT: go to LOCKED, expected <= word+1, locked <= 1.
  - miss_run reaching SLIP_WAIT: bit_shift <= bit_shift+1 (7 wraps to 0), go to SLIP.
- SLIP: discard exactly one valid word (it is stale, formed with the old shift), clear the run counters and ref_valid, return to SEARCH.
- LOCKED, per valid word:
  - word_count++; expected <= expected+1 regardless of the compare result, so one corrupted byte costs exactly one error.
  - word != expected: err_count++, bad_run++. Otherwise bad_run <= 0.
  - bad_run reaching UNLOCK_CNT: go to SEARCH, locked <= 0, lock_lost=1 for one cycle, bit_shift retained, ref_valid <= 0.
- Counters saturate at all-ones and do not wrap.
- clr_counters wins over a simultaneous increment; the result is 0 on the next edge. It does not affect the FSM, bit_shift or the run counters.
- Counting is gated by rx_valid: gaps in rx_valid stall all state and do not count as errors.

Optional Feature:
- Macro CLK_PATTERN_CHECK_EN.
- Defined:
  - Checks clk_lane_data on each rx_valid.
  - The first byte after reset must be 8'hAA or 8'h55 and sets the reference.
  - Any later byte that differs from the reference sets clk_pattern_err, which stays set until rst or clr_counters.
  - Adds one 8-bit reference register and a valid bit.
- Undefined: clk_lane_data is ignored and clk_pattern_err is tied to 0.

Decomposition:
- Shared package loopback_pkg holds:
  - FSM state encoding: SEARCH=2'd0, SLIP=2'd1, LOCKED=2'd2.
  - Pattern constants: CLK_PAT_A=8'hAA, CLK_PAT_B=8'h55.
  - A saturating-increment function.
- One sub-module, byte_aligner (stage 1: prev_byte, barrel select, aligned_valid register). The FSM and counters stay in the top.

Test Plan:
1. Counter bytes 0x00,0x01,... with no rotation: bit_shift stays 0; locked rises after the 17th word plus pipeline delay; err_count=0; word_count equals words sent after lock.
2. Same stream rotated left by 3 bits: the checker steps through shifts until bit_shift=5 and locks; after lock, aligned_word equals the counter sequence and err_count=0.
3. While locked, replace one byte with 0xFF: err_count=1, bad_run resets, locked stays 1, the next correct byte counts no error.
4. While locked, inject 8 consecutive wrong bytes: err_count=8, lock_lost pulses once, locked=0. Clean data then re-locks at the same bit_shift.
5. Assert clr_counters in the same cycle as an error update, then stall rx_valid low for 10 cycles: counters read 0 after the clear, nothing changes during the stall, and lock is held.
6. With CLK_PATTERN_CHECK_EN: clock lane at 0xAA, then one 0x55 byte: clk_pattern_err=1 and stays sticky until clr_counters. Without the macro, the same stimulus gives clk_pattern_err=0.
